wide_add_seq: RTL

Multi-word add sequencer. It time-shares one instance of the team's parameterized ripple adder, fa_multi_bit #(SIZE), to add two WORDS×SIZE-bit operands. Operands stream in one SIZE-bit word per cycle, least-significant word first, over a valid/ready handshake. The carry-out of each word is registered and fed back as the carry-in of the next word. Sum words stream out through a one-entry output register with backpressure.

---
 rtl/wide_add_seq_if.sv | 25 ++
 rtl/wide_add_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - operand and sum word streams for wide_add_seq
interface wide_add_seq_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a_word;
  logic [SIZE-1:0] b_word;
  logic            sum_valid;
  logic            sum_ready;
  logic [SIZE-1:0] sum_word;
  logic            sum_last;

  // Producer of operands / consumer of sums
  modport master (
    output in_valid, a_word, b_word, sum_ready,
    input  in_ready, sum_valid, sum_word, sum_last
  );

  // The sequencer itself
  modport slave (
    input  in_valid, a_word, b_word, sum_ready,
    output in_ready, sum_valid, sum_word, sum_last
  );
endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-word add sequencer time-sharing one ripple adder
module fa_multi_bit #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] s,
  output logic [SIZE:0]   co
);
  logic carry;

  // Ripple chain; co[i] is the carry into bit i, co[SIZE] the word carry-out
  always_comb begin
    carry = ci;
    co[0] = ci;
    s     = '0;
    for (int i = 0; i < SIZE; i++) begin
      s[i]    = a[i] ^ b[i] ^ carry;
      carry   = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      co[i+1] = carry;
    end
  end
endmodule

module wide_add_seq #(
  parameter  int SIZE  = 8,
  parameter  int WORDS = 4,
  localparam int IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cin,
  output logic             busy,
  output logic             cout,
  output logic             done,
  output logic [IDX_W-1:0] word_idx,
  wide_add_seq_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_n;
  logic            carry_reg, carry_n;
  logic [IDX_W-1:0] idx_n;
  logic            sum_valid_q, sum_valid_n;
  logic [SIZE-1:0] sum_word_q, sum_word_n;
  logic            sum_last_q, sum_last_n;
  logic            cout_n;
  logic            done_n;

  logic [SIZE-1:0] add_s;
  logic [SIZE:0]   add_co;
  logic            accept;
  logic            out_hs;
  logic            last_word;

  fa_multi_bit #(.SIZE(SIZE)) u_add (
    .a  (bus.a_word),
    .b  (bus.b_word),
    .ci (carry_reg),
    .s  (add_s),
    .co (add_co)
  );

  // A new word may enter whenever the output register is empty or draining
  assign bus.in_ready  = (state == RUN) && (!sum_valid_q || bus.sum_ready);
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_word  = sum_word_q;
  assign bus.sum_last  = sum_last_q;
  assign busy          = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_hs        = sum_valid_q && bus.sum_ready;
  assign last_word     = (word_idx == IDX_W'(WORDS - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      carry_reg   <= 1'b0;
      word_idx    <= '0;
      sum_valid_q <= 1'b0;
      sum_word_q  <= '0;
      sum_last_q  <= 1'b0;
      cout        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      carry_reg   <= carry_n;
      word_idx    <= idx_n;
      sum_valid_q <= sum_valid_n;
      sum_word_q  <= sum_word_n;
      sum_last_q  <= sum_last_n;
      cout        <= cout_n;
      done        <= done_n;
    end
  end

  // Next-state and next-register values; everything holds unless changed below
  always_comb begin
    state_n     = state;
    carry_n     = carry_reg;
    idx_n       = word_idx;
    sum_valid_n = sum_valid_q;
    sum_word_n  = sum_word_q;
    sum_last_n  = sum_last_q;
    cout_n      = cout;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          carry_n = cin;
          idx_n   = '0;
          cout_n  = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (out_hs) begin
          sum_valid_n = 1'b0;
          sum_last_n  = 1'b0;
        end
        // An accept in the handshake cycle refills the register without a bubble
        if (accept) begin
          sum_word_n  = add_s;
          sum_valid_n = 1'b1;
          carry_n     = add_co[SIZE];
          idx_n       = word_idx + 1'b1;
          if (last_word) begin
            sum_last_n = 1'b1;
            cout_n     = add_co[SIZE];
            state_n    = FLUSH;
          end
        end
      end
      FLUSH: begin
        // done is raised by the final handshake and returns us to IDLE as it drops
        if (done) begin
          state_n = IDLE;
        end else if (out_hs) begin
          sum_valid_n = 1'b0;
          sum_last_n  = 1'b0;
          done_n      = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
